// File: rtl/support_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : support_mem_loader
// Description : Host byte-stream loader for the support RAM system write
//               port. Parses WRITE frames (cmd, addr, len, payload,
//               checksum), writes one payload byte per clock, checks an
//               8-bit two's-complement checksum and owns the CPU hold line.
// Revision    : 1.0 - initial release
// ============================================================================
module support_mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sys_en,
    output logic [15:0] sys_A,
    output logic [7:0]  sys_data,
    output logic        sys_wr,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // Host command bytes recognised in IDLE
    localparam logic [7:0] c_cmd_write   = 8'h55;
    localparam logic [7:0] c_cmd_release = 8'hAA;
    localparam logic [7:0] c_cmd_hold    = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ADRH  = 4'd1,
        ST_ADRL  = 4'd2,
        ST_LENH  = 4'd3,
        ST_LENL  = 4'd4,
        ST_DATA  = 4'd5,
        ST_CSUM  = 4'd6,
        ST_CHECK = 4'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_addr;       // next RAM address to write
    logic [15:0] w_addr_nxt;
    logic [7:0]  r_len_hi;     // len[15:8] held until len[7:0] arrives
    logic [7:0]  w_len_hi_nxt;
    logic [15:0] r_remain;     // payload bytes still expected
    logic [15:0] w_remain_nxt;
    logic [7:0]  r_sum;        // running payload sum, mod 256
    logic [7:0]  w_sum_nxt;
    logic [7:0]  r_csum;       // checksum byte received from host
    logic [7:0]  w_csum_nxt;

    logic        r_sys_en;
    logic        w_sys_en_nxt;
    logic [15:0] r_sys_a;
    logic [15:0] w_sys_a_nxt;
    logic [7:0]  r_sys_data;
    logic [7:0]  w_sys_data_nxt;
    logic        r_sys_wr;
    logic        w_sys_wr_nxt;
    logic        r_cpu_hold;
    logic        w_cpu_hold_nxt;
    logic        r_err_cmd;    // unknown command seen on the previous edge
    logic        w_err_cmd_nxt;

    logic        w_xfer;
    logic [7:0]  w_total;
    logic        w_csum_ok;

    // The loader stalls the host only during the single CHECK cycle, and
    // never accepts while reset is held.
    assign in_ready  = (r_state != ST_CHECK) && !reset;
    assign w_xfer    = in_valid && in_ready;

    // A good packet makes payload sum plus checksum vanish modulo 256.
    assign w_total   = r_sum + r_csum;
    assign w_csum_ok = (w_total == 8'h00);

    assign sys_en    = r_sys_en;
    assign sys_A     = r_sys_a;
    assign sys_data  = r_sys_data;
    assign sys_wr    = r_sys_wr;
    assign cpu_hold  = r_cpu_hold;

    // Verdict pulses are decoded from the CHECK state itself; the command
    // error is a registered flag so it lands one cycle after the bad byte.
    assign done = (r_state == ST_CHECK) && w_csum_ok;
    assign err  = r_err_cmd || ((r_state == ST_CHECK) && !w_csum_ok);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers; reset drops the RAM port ownership
    // and write strobe immediately and re-holds the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= 16'h0000;
            r_len_hi   <= 8'h00;
            r_remain   <= 16'h0000;
            r_sum      <= 8'h00;
            r_csum     <= 8'h00;
            r_sys_en   <= 1'b0;
            r_sys_a    <= 16'h0000;
            r_sys_data <= 8'h00;
            r_sys_wr   <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_err_cmd  <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_len_hi   <= w_len_hi_nxt;
            r_remain   <= w_remain_nxt;
            r_sum      <= w_sum_nxt;
            r_csum     <= w_csum_nxt;
            r_sys_en   <= w_sys_en_nxt;
            r_sys_a    <= w_sys_a_nxt;
            r_sys_data <= w_sys_data_nxt;
            r_sys_wr   <= w_sys_wr_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_err_cmd  <= w_err_cmd_nxt;
        end
    end

    // Frame parser: next state and next register values
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_len_hi_nxt   = r_len_hi;
        w_remain_nxt   = r_remain;
        w_sum_nxt      = r_sum;
        w_csum_nxt     = r_csum;
        w_sys_en_nxt   = r_sys_en;
        w_sys_a_nxt    = r_sys_a;
        w_sys_data_nxt = r_sys_data;
        w_sys_wr_nxt   = 1'b0;       // strobe only follows a DATA transfer
        w_cpu_hold_nxt = r_cpu_hold;
        w_err_cmd_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    case (in_data)
                        c_cmd_write:   w_state_nxt    = ST_ADRH;
                        c_cmd_release: w_cpu_hold_nxt = 1'b0;
                        c_cmd_hold:    w_cpu_hold_nxt = 1'b1;
                        default:       w_err_cmd_nxt  = 1'b1;
                    endcase
                end
            end

            ST_ADRH: begin
                if (w_xfer) begin
                    w_addr_nxt[15:8] = in_data;
                    w_state_nxt      = ST_ADRL;
                end
            end

            ST_ADRL: begin
                if (w_xfer) begin
                    w_addr_nxt[7:0] = in_data;
                    w_state_nxt     = ST_LENH;
                end
            end

            ST_LENH: begin
                if (w_xfer) begin
                    w_len_hi_nxt = in_data;
                    w_state_nxt  = ST_LENL;
                end
            end

            ST_LENL: begin
                if (w_xfer) begin
                    w_remain_nxt = {r_len_hi, in_data};
                    w_sum_nxt    = 8'h00;
                    if ({r_len_hi, in_data} == 16'h0000) begin
                        // Empty payload: RAM port is never taken
                        w_state_nxt = ST_CSUM;
                    end else begin
                        w_sys_en_nxt = 1'b1;
                        w_state_nxt  = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (w_xfer) begin
                    w_sys_a_nxt    = r_addr;
                    w_sys_data_nxt = in_data;
                    w_sys_wr_nxt   = 1'b1;
                    w_addr_nxt     = r_addr + 16'd1;   // wraps 0xFFFF -> 0
                    w_sum_nxt      = r_sum + in_data;
                    w_remain_nxt   = r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end

            ST_CSUM: begin
                if (w_xfer) begin
                    w_csum_nxt  = in_data;
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                // Verdict pulses are decoded combinationally this cycle;
                // release the RAM port once the final write is long done.
                w_sys_en_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end

            default: begin
                w_sys_en_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_support_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_support_mem_loader
// Description : Directed self-checking bench for support_mem_loader with a
//               packet-level model (expected write list, verdict, hold line)
//               compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_support_mem_loader;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sys_en;
    logic [15:0] sys_A;
    logic [7:0]  sys_data;
    logic        sys_wr;
    logic        cpu_hold;
    logic        done;
    logic        err;

    support_mem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sys_en   (sys_en),
        .sys_A    (sys_A),
        .sys_data (sys_data),
        .sys_wr   (sys_wr),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;      // cycle index of the accepting edge
    } wr_t;
    wr_t         exp_q[$];
    logic        exp_hold = 1'b1;
    logic        exp_en   = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;
    logic        chk_en   = 1'b0;

    int          wr_seen   = 0;
    int          done_seen = 0;
    int          err_seen  = 0;
    logic [15:0] last_a    = 16'h0000;
    logic [7:0]  last_d    = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checksum the host must send so that payload sum + checksum == 0 mod 256
    function automatic logic [7:0] model_csum(input logic [7:0] d[8], input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(d[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // One byte handshake; returns 1ns after the accepting edge.
    task automatic xfer(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stuck 0 for byte %0h", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_packet(input logic [15:0] a, input logic [15:0] len,
                               input logic [7:0] d[8], input logic [7:0] cs,
                               input int maxgap);
        logic [15:0] ad  = a;
        logic [7:0]  s   = 8'h00;
        logic        good;
        int          wr0 = wr_seen;
        int          dn0 = done_seen;
        int          er0 = err_seen;
        xfer(8'h55);
        xfer(a[15:8]);
        xfer(a[7:0]);
        xfer(len[15:8]);
        xfer(len[7:0]);
        exp_en = (len != 16'h0000);
        for (int i = 0; i < int'(len); i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            xfer(d[i]);
            exp_q.push_back('{ad, d[i], cyc});
            ad = ad + 16'd1;
            s  = s + d[i];
        end
        xfer(cs);
        good     = (8'(s + cs) == 8'h00);
        exp_done = good;
        exp_err  = !good;
        chk("check_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_en   = 1'b0;
        chk("pkt_write_count", wr_seen - wr0, len);
        chk("pkt_done_count", done_seen - dn0, good ? 1 : 0);
        chk("pkt_err_count", err_seen - er0, good ? 0 : 1);
    endtask

    // Cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_hold", cpu_hold, exp_hold);
            chk("sys_en", sys_en, exp_en);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            if (done) done_seen++;
            if (err)  err_seen++;
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_write: addr %0h data %0h never written", exp_q[0].a, exp_q[0].d);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                chk("sys_wr", sys_wr, 1);
                chk("sys_A", sys_A, exp_q[0].a);
                chk("sys_data", sys_data, exp_q[0].d);
                void'(exp_q.pop_front());
            end else begin
                chk("sys_wr_idle", sys_wr, 0);
            end
            if (sys_wr) begin
                wr_seen++;
                last_a = sys_A;
                last_d = sys_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pk[8];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sys_en", sys_en, 0);
        chk("rst_sys_A", sys_A, 0);
        chk("rst_sys_data", sys_data, 0);
        chk("rst_sys_wr", sys_wr, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_hold", cpu_hold, 1);
        chk_en = 1'b1;

        // Pin the checksum model with hand-computed values
        pk = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_csum_123", model_csum(pk, 3), 8'hFA);

        // RELEASE / HOLD
        xfer(8'hAA);
        exp_hold = 1'b0;
        chk("release_hold", cpu_hold, 0);
        xfer(8'h5A);
        exp_hold = 1'b1;
        chk("hold_again", cpu_hold, 1);

        // Good packet, continuous valid
        send_packet(16'h1234, 16'd3, pk, 8'hFA, 0);
        chk("pk1_last_addr", last_a, 16'h1236);
        chk("pk1_last_data", last_d, 8'h03);
        chk("pk1_en_low", sys_en, 0);

        // Same packet, bad checksum
        send_packet(16'h1234, 16'd3, pk, 8'hFB, 0);

        // Address wrap
        pk = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_csum_aabb", model_csum(pk, 2), 8'h9B);
        send_packet(16'hFFFF, 16'd2, pk, 8'h9B, 0);
        chk("wrap_last_addr", last_a, 16'h0000);
        chk("wrap_last_data", last_d, 8'hBB);

        // Zero-length packet
        send_packet(16'h0010, 16'd0, pk, 8'h00, 0);

        // Unknown command in IDLE
        xfer(8'h33);
        exp_err = 1'b1;
        chk("bad_cmd_err", err, 1);
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        chk("bad_cmd_err_clear", err, 0);
        chk("bad_cmd_idle_ready", in_ready, 1);

        // Gapped payload
        pk = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h00, 8'h00, 8'h00};
        send_packet(16'h2000, 16'd5, pk, model_csum(pk, 5), 3);
        chk("gap_last_addr", last_a, 16'h2004);

        // Reset mid-packet with the CPU running
        xfer(8'hAA);
        exp_hold = 1'b0;
        xfer(8'h55);
        xfer(8'h00);
        xfer(8'h20);
        xfer(8'h00);
        xfer(8'h04);
        exp_en = 1'b1;
        xfer(8'h11);
        exp_q.push_back('{16'h0020, 8'h11, cyc});
        xfer(8'h22);
        #2;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midrst_sys_en", sys_en, 0);
        chk("midrst_sys_wr", sys_wr, 0);
        chk("midrst_cpu_hold", cpu_hold, 1);
        chk("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        exp_en   = 1'b0;
        exp_hold = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Next packet completes normally
        pk = '{8'h05, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(16'h0040, 16'd3, pk, model_csum(pk, 3), 1);
        chk("after_rst_last_addr", last_a, 16'h0042);
        chk("after_rst_last_data", last_d, 8'h07);

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
